// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EXE/MEM/WB dependency info and SRAM status in, stall/flush/forward controls out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic             exe_wb_en;
  logic [3:0]       exe_dest;
  logic             exe_mem_r_en;
  logic             mem_wb_en;
  logic [3:0]       mem_dest;
  logic             wb_wb_en;
  logic [3:0]       wb_dest;
  logic             mem_req;
  logic             sram_ready;
  logic             branch_taken;
  logic             hazard;
  logic             freeze_all;
  logic             flush;
  logic [1:0]       fwd_sel_a;
  logic [1:0]       fwd_sel_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_src1, id_src2, id_two_src, exe_wb_en, exe_dest, exe_mem_r_en,
           mem_wb_en, mem_dest, wb_wb_en, wb_dest, mem_req, sram_ready, branch_taken,
    input  hazard, freeze_all, flush, fwd_sel_a, fwd_sel_b, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, exe_wb_en, exe_dest, exe_mem_r_en,
           mem_wb_en, mem_dest, wb_wb_en, wb_dest, mem_req, sram_ready, branch_taken,
    output hazard, freeze_all, flush, fwd_sel_a, fwd_sel_b, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush sequencer: SRAM-wait freeze FSM, branch flush, RAW hazard detect, stall counter.
// Define FORWARDING_EN for load-use-only hazards plus EXE operand forwarding selects.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               r_mem_timeout;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic               w_freeze;
  logic               w_flush;
  logic               w_hazard;
  logic               w_raw_hazard;
  logic [1:0]         w_fwd_a;
  logic [1:0]         w_fwd_b;

  // Freeze is Mealy so an SRAM that answers in the request cycle costs nothing.
  always_comb begin
    w_freeze = 1'b0;
    if (r_state == RUN) w_freeze = bus.mem_req & ~bus.sram_ready;
    else                w_freeze = ~bus.sram_ready;
  end

  assign w_flush  = bus.branch_taken & ~w_freeze;
  assign w_hazard = w_raw_hazard & ~bus.branch_taken & ~w_freeze;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.mem_req && !bus.sram_ready) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.sram_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            // Timeout becomes visible in the same cycle the count reaches MAX_WAIT.
            if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1)) r_mem_timeout <= 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            r_stall_cnt <= '0;
    else if ((w_hazard || w_freeze) && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

`ifdef FORWARDING_EN
  logic [3:0] r_exe_src1;
  logic [3:0] r_exe_src2;
  logic       r_exe_two_src;

  // Only a load in EXE cannot be bypassed; everything else is forwarded next cycle.
  assign w_raw_hazard = ((bus.id_src1 == bus.exe_dest) |
                         (bus.id_two_src & (bus.id_src2 == bus.exe_dest)))
                        & bus.exe_wb_en & bus.exe_mem_r_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exe_src1    <= '0;
      r_exe_src2    <= '0;
      r_exe_two_src <= 1'b0;
    end else if (w_flush || w_hazard) begin
      r_exe_src1    <= '0;
      r_exe_src2    <= '0;
      r_exe_two_src <= 1'b0;
    end else if (!w_freeze) begin
      r_exe_src1    <= bus.id_src1;
      r_exe_src2    <= bus.id_src2;
      r_exe_two_src <= bus.id_two_src;
    end
  end

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_exe_src1 == bus.mem_dest && bus.mem_wb_en)     w_fwd_a = 2'b01;
    else if (r_exe_src1 == bus.wb_dest && bus.wb_wb_en)  w_fwd_a = 2'b10;
    if (r_exe_two_src) begin
      if (r_exe_src2 == bus.mem_dest && bus.mem_wb_en)    w_fwd_b = 2'b01;
      else if (r_exe_src2 == bus.wb_dest && bus.wb_wb_en) w_fwd_b = 2'b10;
    end
  end
`else
  logic w_m1;
  logic w_m2;
  logic w_unused_fwd;

  assign w_m1 = ((bus.id_src1 == bus.exe_dest) & bus.exe_wb_en) |
                ((bus.id_src1 == bus.mem_dest) & bus.mem_wb_en);
  assign w_m2 = bus.id_two_src &
                (((bus.id_src2 == bus.exe_dest) & bus.exe_wb_en) |
                 ((bus.id_src2 == bus.mem_dest) & bus.mem_wb_en));
  assign w_raw_hazard = w_m1 | w_m2;
  assign w_fwd_a      = 2'b00;
  assign w_fwd_b      = 2'b00;
  assign w_unused_fwd = ^{bus.wb_wb_en, bus.wb_dest, bus.exe_mem_r_en};
`endif

  assign bus.freeze_all  = w_freeze;
  assign bus.flush       = w_flush;
  assign bus.hazard      = w_hazard;
  assign bus.fwd_sel_a   = w_fwd_a;
  assign bus.fwd_sel_b   = w_fwd_b;
  assign bus.mem_timeout = r_mem_timeout;
  assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl; expectations are hand-derived per cycle and queued at drive time.
module tb_pipeline_hazard_ctrl;
  localparam int CW = 5;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic       exe_wb_en;
    logic [3:0] exe_dest;
    logic       exe_mem_r_en;
    logic       mem_wb_en;
    logic [3:0] mem_dest;
    logic       wb_wb_en;
    logic [3:0] wb_dest;
    logic       mem_req;
    logic       sram_ready;
    logic       branch_taken;
  } stim_t;

  // {hazard, freeze_all, flush, fwd_sel_a, fwd_sel_b, mem_timeout, stall_cnt}
  typedef logic [7+CW:0] obs_t;

  typedef struct {
    stim_t s;
    obs_t  e;
  } row_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  obs_t sb[$];

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(int s1, int s2, int two, int ewb, int ed, int erd,
                               int mwb, int md, int wwb, int wd, int mreq, int rdy, int br);
    stim_t s;
    s.id_src1      = 4'(s1);
    s.id_src2      = 4'(s2);
    s.id_two_src   = 1'(two);
    s.exe_wb_en    = 1'(ewb);
    s.exe_dest     = 4'(ed);
    s.exe_mem_r_en = 1'(erd);
    s.mem_wb_en    = 1'(mwb);
    s.mem_dest     = 4'(md);
    s.wb_wb_en     = 1'(wwb);
    s.wb_dest      = 4'(wd);
    s.mem_req      = 1'(mreq);
    s.sram_ready   = 1'(rdy);
    s.branch_taken = 1'(br);
    return s;
  endfunction

  function automatic obs_t ex(int haz, int frz, int fl, int fa, int fb, int tmo, int cnt);
    return {1'(haz), 1'(frz), 1'(fl), 2'(fa), 2'(fb), 1'(tmo), CW'(cnt)};
  endfunction

  function automatic obs_t sample();
    return {bus.hazard, bus.freeze_all, bus.flush, bus.fwd_sel_a, bus.fwd_sel_b,
            bus.mem_timeout, bus.stall_cnt};
  endfunction

  task automatic drive(input stim_t s);
    bus.id_src1      = s.id_src1;
    bus.id_src2      = s.id_src2;
    bus.id_two_src   = s.id_two_src;
    bus.exe_wb_en    = s.exe_wb_en;
    bus.exe_dest     = s.exe_dest;
    bus.exe_mem_r_en = s.exe_mem_r_en;
    bus.mem_wb_en    = s.mem_wb_en;
    bus.mem_dest     = s.mem_dest;
    bus.wb_wb_en     = s.wb_wb_en;
    bus.wb_dest      = s.wb_dest;
    bus.mem_req      = s.mem_req;
    bus.sram_ready   = s.sram_ready;
    bus.branch_taken = s.branch_taken;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive('0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t want;
    rst = 1'b0;
    drive('0);
    #1;
    sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_initial got=%b want=%b", got, want); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(mk(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0));
      sb.push_back(ex(0, 1, 0, 0, 0, 0, i));
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset_buildup[%0d] got=%b want=%b", i, got, want); end
    end
    @(posedge clk); #1;
    sb.push_back(ex(0, 1, 0, 0, 0, 0, 5));
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_pre_wait got=%b want=%b", got, want); end
    // Idle inputs with sram_ready low would still freeze if the FSM were left in MEM_WAIT.
    rst = 1'b0;
    drive('0);
    #1;
    sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_mid_wait got=%b want=%b", got, want); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_after_release got=%b want=%b", got, want); end
  endtask

  task automatic test_raw_hazard();
    row_t tbl[7];
    obs_t got;
    obs_t want;
    tbl[0] = '{mk(3,0,0, 1,3,0, 0,0, 0,0, 0,0,0), FWD ? ex(0,0,0,0,0,0,0) : ex(1,0,0,0,0,0,0)};
    tbl[1] = '{mk(7,7,1, 0,0,0, 1,3, 0,0, 0,0,0), FWD ? ex(0,0,0,1,0,0,0) : ex(0,0,0,0,0,0,1)};
    tbl[2] = '{mk(9,9,1, 0,0,0, 1,7, 1,7, 0,0,0), FWD ? ex(0,0,0,1,1,0,0) : ex(0,0,0,0,0,0,1)};
    tbl[3] = '{mk(2,2,0, 0,0,0, 0,0, 1,9, 0,0,0), FWD ? ex(0,0,0,2,2,0,0) : ex(0,0,0,0,0,0,1)};
    tbl[4] = '{mk(0,0,0, 0,0,0, 1,2, 1,2, 0,0,0), FWD ? ex(0,0,0,1,0,0,0) : ex(0,0,0,0,0,0,1)};
    tbl[5] = '{mk(0,0,0, 1,0,0, 0,0, 0,0, 0,0,0), FWD ? ex(0,0,0,0,0,0,0) : ex(1,0,0,0,0,0,1)};
    tbl[6] = '{mk(1,4,1, 0,0,0, 1,4, 0,0, 0,0,0), FWD ? ex(0,0,0,0,0,0,0) : ex(1,0,0,0,0,0,2)};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].s);
      sb.push_back(tbl[i].e);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL raw_hazard[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_load_use();
    row_t tbl[4];
    obs_t got;
    obs_t want;
    tbl[0] = '{mk(1,5,1, 1,5,1, 0,0, 0,0, 0,0,0), ex(1,0,0,0,0,0,0)};
    tbl[1] = '{mk(1,5,0, 1,5,1, 0,0, 0,0, 0,0,0), ex(0,0,0,0,0,0,1)};
    tbl[2] = '{mk(5,0,0, 1,5,1, 0,0, 0,0, 0,0,0), ex(1,0,0,0,0,0,1)};
    tbl[3] = '{mk(5,0,0, 0,5,1, 0,0, 0,0, 0,0,0), ex(0,0,0,0,0,0,2)};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].s);
      sb.push_back(tbl[i].e);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL load_use[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_mem_stall();
    row_t tbl[8];
    obs_t got;
    obs_t want;
    tbl[0] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0), ex(0,1,0,0,0,0,0)};
    tbl[1] = '{mk(3,0,0, 1,3,1, 0,0, 0,0, 1,0,0), ex(0,1,0,0,0,0,1)};
    tbl[2] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0), ex(0,1,0,0,0,0,2)};
    tbl[3] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0), ex(0,0,0,0,0,0,3)};
    tbl[4] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0), ex(0,0,0,0,0,0,3)};
    tbl[5] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0), ex(0,1,0,0,0,0,3)};
    tbl[6] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0), ex(0,0,0,0,0,0,4)};
    tbl[7] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0), ex(0,0,0,0,0,0,4)};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].s);
      sb.push_back(tbl[i].e);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL mem_stall[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_timeout_saturate();
    obs_t got;
    obs_t want;
    apply_reset();
    for (int i = 0; i < 36; i++) begin
      @(posedge clk); #1;
      if (i < 34) begin
        drive(mk(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0));
        sb.push_back(ex(0, 1, 0, 0, 0, (i >= 16) ? 1 : 0, (i > 31) ? 31 : i));
      end else if (i == 34) begin
        drive(mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,0));
        sb.push_back(ex(0, 0, 0, 0, 0, 1, 31));
      end else begin
        drive('0);
        sb.push_back(ex(0, 0, 0, 0, 0, 1, 31));
      end
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL timeout_sat[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_branch();
    row_t tbl[6];
    obs_t got;
    obs_t want;
    tbl[0] = '{mk(3,0,0, 1,3,1, 0,0, 0,0, 0,0,1), ex(0,0,1,0,0,0,0)};
    tbl[1] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 1,0,1), ex(0,1,0,0,0,0,0)};
    tbl[2] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 1,0,1), ex(0,1,0,0,0,0,1)};
    tbl[3] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 1,1,1), ex(0,0,1,0,0,0,2)};
    tbl[4] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0), ex(0,0,0,0,0,0,2)};
    tbl[5] = '{mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,1), ex(0,0,1,0,0,0,2)};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].s);
      sb.push_back(tbl[i].e);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL branch[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_raw_hazard();
    test_load_use();
    test_mem_stall();
    test_timeout_saturate();
    test_branch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
